// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory controller.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_e;

   function automatic int size_bytes(input size_e sz);
      return 1 << sz;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for dmem_ctrl: store enables and shift, load extract and
// extend, and the misalignment flag.
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int BE_W   = DATA_W / 8,
   localparam int OFF_W  = $clog2(BE_W)
) (
   input  size_e             size,
   input  logic [OFF_W-1:0]  offset,
   input  logic              sgn,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rword,
   output logic [BE_W-1:0]   be,
   output logic [DATA_W-1:0] wlane,
   output logic [DATA_W-1:0] rdata,
   output logic              misalign
);

   logic [7:0]        nmask;
   logic [DATA_W-1:0] rshift;
   logic [DATA_W-1:0] keep;
   logic [DATA_W-1:0] topbit;
   int                nbits;

   always_comb begin
      unique case (size)
         SZ_B:    nmask = 8'h01;
         SZ_H:    nmask = 8'h03;
         SZ_W:    nmask = 8'h0f;
         default: nmask = 8'hff;
      endcase
      be    = BE_W'(nmask) << offset;
      wlane = wdata << {offset, 3'b000};

      // keep masks the accessed bits; a full-width access leaves ~keep empty,
      // so sign extension has nothing to fill.
      nbits = 8 * size_bytes(size);
      if (nbits > DATA_W) nbits = DATA_W;
      keep   = (nbits >= DATA_W) ? '1 : ~({DATA_W{1'b1}} << nbits);
      topbit = keep & ~(keep >> 1);
      rshift = rword >> {offset, 3'b000};
      rdata  = (rshift & keep) | ((sgn && |(rshift & topbit)) ? ~keep : '0);

      misalign = (int'(offset) & (size_bytes(size) - 1)) != 0;
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with valid/ready request and response handshakes.
// Optional per-lane even parity is enabled by defining DMEM_PARITY_EN.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 32,
   parameter  int DEPTH  = 1024,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_perr
);

   // state  | meaning
   // IDLE   | ready for a request; fields latched on accept
   // ACCESS | error check, array read or masked write
   // RESP   | response held until rsp_ready

   localparam int OFF_W = $clog2(BE_W);
   localparam int IDX_W = $clog2(DEPTH);

   state_e            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic              sgn_q;
   size_e             size_q;
   logic [DATA_W-1:0] wdata_q;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic [OFF_W-1:0]  off;
   logic [DATA_W-1:0] rword;
   logic [DATA_W-1:0] wlane;
   logic [DATA_W-1:0] rdata_ext;
   logic [BE_W-1:0]   be;
   logic              misalign;
   logic              oor;
   logic              bad_size;
   logic              err;
   logic              do_write;
   logic              perr_hit;

   assign idx      = addr_q[OFF_W +: IDX_W];
   assign off      = addr_q[OFF_W-1:0];
   assign rword    = mem[idx];
   assign oor      = (addr_q >> (OFF_W + IDX_W)) != '0;
   assign bad_size = (size_q == SZ_D) && (DATA_W == 32);
   assign err      = oor || bad_size || misalign;
   // A synchronous reset landing in ACCESS must not let the store through.
   assign do_write = (state == ACCESS) && we_q && !err && !rst;

   dmem_lane_align #(.DATA_W(DATA_W)) u_align (
      .size     (size_q),
      .offset   (off),
      .sgn      (sgn_q),
      .wdata    (wdata_q),
      .rword    (rword),
      .be       (be),
      .wlane    (wlane),
      .rdata    (rdata_ext),
      .misalign (misalign)
   );

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = ACCESS;
         end
         ACCESS: state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         rsp_perr  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ACCESS) begin
            rsp_err   <= err;
            rsp_rdata <= (we_q || err) ? '0 : rdata_ext;
            rsp_perr  <= !we_q && !err && perr_hit;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         addr_q  <= req_addr;
         we_q    <= req_we;
         size_q  <= size_e'(req_size);
         sgn_q   <= req_signed;
         wdata_q <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (do_write)
         for (int i = 0; i < BE_W; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
   end

`ifdef DMEM_PARITY_EN
   logic [BE_W-1:0] par_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (do_write)
         for (int i = 0; i < BE_W; i++)
            if (be[i]) par_mem[idx][i] <= ^wlane[8*i +: 8];
   end

   // Only lanes the load touches can flag a parity error.
   always_comb begin
      perr_hit = 1'b0;
      for (int i = 0; i < BE_W; i++)
         if (be[i] && ((^rword[8*i +: 8]) != par_mem[idx][i])) perr_hit = 1'b1;
   end
`else
   assign perr_hit = 1'b0;
`endif

endmodule
